// File: rtl/lb_regbank_resp.sv
`default_nettype none
// ============================================================================
// Module  : lb_regbank_resp
// Brief   : Local-bus control/status register bank with a fixed-latency read
//           pipeline. Optional shadowed writes with COMMIT: LB_REGBANK_SHADOW_EN
// Revision: 1.0
// ============================================================================
module lb_regbank_resp #(
    parameter int                  DW         = 32,
    parameter int                  AW         = 8,
    parameter int                  NCTRL      = 16,
    parameter int                  NSTAT      = 16,
    parameter int                  RDLAT      = 2,
    parameter logic [NCTRL-1:0]    PULSE_MASK = '0,
    parameter logic [NCTRL*DW-1:0] CTRL_INIT  = '0
) (
    input  logic                  lb_clk,
    input  logic                  lb_reset,
    input  logic                  lb_wen,
    input  logic [AW-1:0]         lb_waddr,
    input  logic [DW-1:0]         lb_wdata,
    input  logic                  lb_ren,
    input  logic [AW-1:0]         lb_raddr,
    output logic                  lb_rvalid,
    output logic [DW-1:0]         lb_rdata,
    output logic                  lb_rerr,
    output logic [NCTRL*DW-1:0]   ctrl_q,
    output logic [NCTRL-1:0]      ctrl_wstb,
    input  logic [NSTAT*DW-1:0]   stat_d
);

    localparam logic [31:0]   c_ADDR_STAT   = 32'h80;
    localparam logic [31:0]   c_ADDR_COMMIT = 32'hFF;
    localparam logic [DW-1:0] c_BAD_DATA    = DW'(32'hDEADBEEF);

    logic [31:0]      w_waddr_ext;
    logic [31:0]      w_raddr_ext;
    logic [NCTRL-1:0] w_ctrl_hit;
    logic [DW-1:0]    w_rd_data;
    logic             w_rd_err;

    logic [DW-1:0]    r_ctrl [NCTRL];
    logic [NCTRL-1:0] r_wstb;
    logic [RDLAT-1:0] r_pv;
    logic [RDLAT-1:0] r_pe;
    logic [DW-1:0]    r_pd [RDLAT];

    assign w_waddr_ext = 32'(lb_waddr);
    assign w_raddr_ext = 32'(lb_raddr);

    always_comb begin
        w_ctrl_hit = '0;
        for (int i = 0; i < NCTRL; i++) begin
            w_ctrl_hit[i] = lb_wen && (w_waddr_ext == 32'(i));
        end
    end

`ifdef LB_REGBANK_SHADOW_EN
    logic [DW-1:0]    r_shadow [NCTRL];
    logic [NCTRL-1:0] r_dirty;
    logic             w_commit;

    assign w_commit = lb_wen && (w_waddr_ext == c_ADDR_COMMIT);

    // Control writes park in the shadow; COMMIT publishes every shadow at once
    // and strobes only the registers written since the previous commit.
    always_ff @(posedge lb_clk) begin
        if (lb_reset) begin
            for (int i = 0; i < NCTRL; i++) begin
                r_shadow[i] <= CTRL_INIT[i*DW +: DW];
                r_ctrl[i]   <= CTRL_INIT[i*DW +: DW];
            end
            r_dirty <= '0;
            r_wstb  <= '0;
        end else begin
            for (int i = 0; i < NCTRL; i++) begin
                if (w_ctrl_hit[i]) begin
                    r_shadow[i] <= lb_wdata;
                end
                if (w_commit) begin
                    r_ctrl[i] <= r_shadow[i];
                end else if (PULSE_MASK[i]) begin
                    r_ctrl[i] <= '0;
                end
            end
            r_wstb  <= w_commit ? r_dirty : '0;
            r_dirty <= w_commit ? '0 : (r_dirty | w_ctrl_hit);
        end
    end
`else
    always_ff @(posedge lb_clk) begin
        if (lb_reset) begin
            for (int i = 0; i < NCTRL; i++) begin
                r_ctrl[i] <= CTRL_INIT[i*DW +: DW];
            end
            r_wstb <= '0;
        end else begin
            for (int i = 0; i < NCTRL; i++) begin
                if (w_ctrl_hit[i]) begin
                    r_ctrl[i] <= lb_wdata;
                end else if (PULSE_MASK[i]) begin
                    r_ctrl[i] <= '0;
                end
            end
            r_wstb <= w_ctrl_hit;
        end
    end
`endif

    // Read source select uses pre-write register state, so a same-cycle
    // write to the read address is not visible to that read.
    always_comb begin
        w_rd_data = c_BAD_DATA;
        w_rd_err  = 1'b1;
        for (int i = 0; i < NCTRL; i++) begin
            if (w_raddr_ext == 32'(i)) begin
`ifdef LB_REGBANK_SHADOW_EN
                w_rd_data = r_shadow[i];
`else
                w_rd_data = r_ctrl[i];
`endif
                w_rd_err  = 1'b0;
            end
        end
        for (int j = 0; j < NSTAT; j++) begin
            if (w_raddr_ext == (c_ADDR_STAT + 32'(j))) begin
                w_rd_data = stat_d[j*DW +: DW];
                w_rd_err  = 1'b0;
            end
        end
`ifdef LB_REGBANK_SHADOW_EN
        if (w_raddr_ext == c_ADDR_COMMIT) begin
            w_rd_data = '0;
            w_rd_err  = 1'b0;
        end
`endif
    end

    // Bubbles carry zero data/err so the output needs no extra gating.
    always_ff @(posedge lb_clk) begin
        if (lb_reset) begin
            r_pv <= '0;
            r_pe <= '0;
            for (int k = 0; k < RDLAT; k++) begin
                r_pd[k] <= '0;
            end
        end else begin
            r_pv[0] <= lb_ren;
            r_pe[0] <= lb_ren & w_rd_err;
            r_pd[0] <= lb_ren ? w_rd_data : '0;
            for (int k = 1; k < RDLAT; k++) begin
                r_pv[k] <= r_pv[k-1];
                r_pe[k] <= r_pe[k-1];
                r_pd[k] <= r_pd[k-1];
            end
        end
    end

    assign lb_rvalid = r_pv[RDLAT-1];
    assign lb_rerr   = r_pe[RDLAT-1];
    assign lb_rdata  = r_pd[RDLAT-1];
    assign ctrl_wstb = r_wstb;

    generate
        for (genvar gi = 0; gi < NCTRL; gi++) begin : g_ctrl_q
            assign ctrl_q[gi*DW +: DW] = r_ctrl[gi];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_lb_regbank_resp.sv
`default_nettype none
// ============================================================================
// Module  : tb_lb_regbank_resp
// Brief   : Directed + random self-checking bench for lb_regbank_resp
// Revision: 1.0
// ============================================================================
module tb_lb_regbank_resp;

    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int NCTRL = 16;
    localparam int NSTAT = 16;
    localparam int RDLAT = 2;
    localparam int VW    = NCTRL * DW;
    localparam logic [NCTRL-1:0] c_PM   = 16'h0020;
    localparam logic [VW-1:0]    c_INIT = (VW'(32'h0000BEEF) << (9 * DW)) | VW'(32'hCAFE0001);

    logic                clk = 1'b0;
    logic                rst, wen, ren;
    logic [AW-1:0]       waddr, raddr;
    logic [DW-1:0]       wdata, rdata;
    logic                rvalid, rerr;
    logic [VW-1:0]       ctrl_q;
    logic [NCTRL-1:0]    wstb;
    logic [NSTAT*DW-1:0] stat;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [DW-1:0]    m_ctrl [NCTRL];
    logic [DW-1:0]    m_sh   [NCTRL];
    logic [NCTRL-1:0] m_dirty;
    logic [NCTRL-1:0] m_wstb;
    bit               e_v [0:2047];
    bit               e_e [0:2047];
    logic [DW-1:0]    e_d [0:2047];

    lb_regbank_resp #(
        .DW(DW), .AW(AW), .NCTRL(NCTRL), .NSTAT(NSTAT), .RDLAT(RDLAT),
        .PULSE_MASK(c_PM), .CTRL_INIT(c_INIT)
    ) u_dut (
        .lb_clk(clk), .lb_reset(rst),
        .lb_wen(wen), .lb_waddr(waddr), .lb_wdata(wdata),
        .lb_ren(ren), .lb_raddr(raddr),
        .lb_rvalid(rvalid), .lb_rdata(rdata), .lb_rerr(rerr),
        .ctrl_q(ctrl_q), .ctrl_wstb(wstb), .stat_d(stat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_read(input int a, output logic [DW-1:0] d, output logic e);
        d = DW'(32'hDEADBEEF);
        e = 1'b1;
        if (a < NCTRL) begin
`ifdef LB_REGBANK_SHADOW_EN
            d = m_sh[a];
`else
            d = m_ctrl[a];
`endif
            e = 1'b0;
        end else if (a >= 'h80 && a < 'h80 + NSTAT) begin
            d = stat[(a - 'h80) * DW +: DW];
            e = 1'b0;
        end
`ifdef LB_REGBANK_SHADOW_EN
        else if (a == 'hFF) begin
            d = '0;
            e = 1'b0;
        end
`endif
    endfunction

    function automatic logic [VW-1:0] model_flat();
        logic [VW-1:0] f;
        for (int i = 0; i < NCTRL; i++) f[i*DW +: DW] = m_ctrl[i];
        return f;
    endfunction

    // Advance the model by one cycle from the currently driven inputs, clock
    // the DUT, then compare every output against the model.
    task automatic step();
        logic [DW-1:0] d;
        logic          e;
        int            a;
        m_wstb = '0;
        if (rst) begin
            for (int i = 0; i < NCTRL; i++) begin
                m_ctrl[i] = c_INIT[i*DW +: DW];
                m_sh[i]   = c_INIT[i*DW +: DW];
            end
            m_dirty = '0;
            for (int k = cyc + 1; k <= cyc + RDLAT; k++) begin
                e_v[k] = 1'b0;
                e_e[k] = 1'b0;
            end
        end else begin
            if (ren) begin
                ref_read(int'(raddr), d, e);
                e_v[cyc + RDLAT] = 1'b1;
                e_d[cyc + RDLAT] = d;
                e_e[cyc + RDLAT] = e;
            end
            for (int i = 0; i < NCTRL; i++) if (c_PM[i]) m_ctrl[i] = '0;
            if (wen) begin
                a = int'(waddr);
`ifdef LB_REGBANK_SHADOW_EN
                if (a < NCTRL) begin
                    m_sh[a]    = wdata;
                    m_dirty[a] = 1'b1;
                end else if (a == 'hFF) begin
                    for (int i = 0; i < NCTRL; i++) m_ctrl[i] = m_sh[i];
                    m_wstb  = m_dirty;
                    m_dirty = '0;
                end
`else
                if (a < NCTRL) begin
                    m_ctrl[a] = wdata;
                    m_wstb[a] = 1'b1;
                end
`endif
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        chk($sformatf("ctrl_q@%0d", cyc), ctrl_q, model_flat());
        chk($sformatf("wstb@%0d", cyc), wstb, m_wstb);
        chk($sformatf("rvalid@%0d", cyc), rvalid, e_v[cyc]);
        chk($sformatf("rdata@%0d", cyc), rdata, e_v[cyc] ? e_d[cyc] : '0);
        chk($sformatf("rerr@%0d", cyc), rerr, e_v[cyc] ? e_e[cyc] : 1'b0);
    endtask

    initial begin
        rst = 1'b1; wen = 1'b0; ren = 1'b0;
        waddr = '0; raddr = '0; wdata = '0; stat = '0;

        // reset values
        step();
        step();
        chk("reset_ctrl0", ctrl_q[0 +: DW], 32'hCAFE0001);
        chk("reset_ctrl9", ctrl_q[9*DW +: DW], 32'h0000BEEF);
        chk("reset_wstb", wstb, 0);
        chk("reset_rvalid", rvalid, 0);

        // read of a zero-initialised control register
        rst = 1'b0;
        step();
        ren = 1'b1; raddr = 8'd3;
        step();
        chk("rd3_early", rvalid, 0);
        ren = 1'b0;
        step();
        chk("rd3_rvalid", rvalid, 1);
        chk("rd3_rdata", rdata, 0);
        chk("rd3_rerr", rerr, 0);

`ifdef LB_REGBANK_SHADOW_EN
        wen = 1'b1; waddr = 8'd1; wdata = 32'd7;
        step();
        wen = 1'b0;
        chk("sh_ctrl1_hold", ctrl_q[DW +: DW], 0);
        chk("sh_wstb_none", wstb, 0);
        ren = 1'b1; raddr = 8'd1;
        step();
        ren = 1'b0;
        step();
        chk("sh_rd1", rdata, 32'd7);
        wen = 1'b1; waddr = 8'hFF; wdata = $urandom;
        step();
        wen = 1'b0;
        chk("sh_commit_ctrl1", ctrl_q[DW +: DW], 32'd7);
        chk("sh_commit_wstb", wstb, 16'h0002);
        ren = 1'b1; raddr = 8'hFF;
        step();
        ren = 1'b0;
        step();
        chk("sh_rdff_data", rdata, 0);
        chk("sh_rdff_err", rerr, 0);
`else
        // write plus same-cycle read of the same address
        wen = 1'b1; waddr = 8'd2; wdata = 32'h12345678;
        ren = 1'b1; raddr = 8'd2;
        step();
        wen = 1'b0; ren = 1'b0;
        chk("wr2_ctrl2", ctrl_q[2*DW +: DW], 32'h12345678);
        chk("wr2_wstb", wstb, 16'h0004);
        step();
        chk("wr2_wstb_clr", wstb, 0);
        chk("wr2_old_rdata", rdata, 0);

        // self-clearing register
        wen = 1'b1; waddr = 8'd5; wdata = 32'h1;
        step();
        wen = 1'b0;
        chk("pulse5_set", ctrl_q[5*DW +: DW], 32'h1);
        step();
        chk("pulse5_clr", ctrl_q[5*DW +: DW], 0);

        // COMMIT address is out of range without shadowing
        ren = 1'b1; raddr = 8'hFF;
        step();
        ren = 1'b0;
        step();
        chk("rdff_data", rdata, 32'hDEADBEEF);
        chk("rdff_err", rerr, 1);
`endif

        // status reads followed by an out-of-range read
        stat[0 +: DW]  = 32'hA5;
        stat[DW +: DW] = 32'h5A;
        ren = 1'b1; raddr = 8'h80;
        step();
        raddr = 8'h81;
        step();
        chk("st0_data", rdata, 32'hA5);
        raddr = 8'h40;
        step();
        chk("st1_data", rdata, 32'h5A);
        ren = 1'b0;
        step();
        chk("oor_data", rdata, 32'hDEADBEEF);
        chk("oor_err", rerr, 1);

        // reads in flight when reset arrives are dropped
        ren = 1'b1; raddr = 8'd0;
        step();
        rst = 1'b1;
        step();
        chk("flush_a", rvalid, 0);
        ren = 1'b0;
        step();
        chk("flush_b", rvalid, 0);
        rst = 1'b0;
        step();
        chk("flush_c", rvalid, 0);

        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            for (int j = 0; j < NSTAT; j++) stat[j*DW +: DW] = $urandom;
            rst   = ($urandom_range(0, 63) == 0);
            wen   = $urandom_range(0, 1) == 1;
            ren   = $urandom_range(0, 2) != 0;
            wdata = $urandom;
            case ($urandom_range(0, 8))
                0, 1, 2, 3: waddr = AW'($urandom_range(0, NCTRL - 1));
                4:          waddr = AW'($urandom_range('h80, 'h80 + NSTAT - 1));
                5, 6:       waddr = 8'hFF;
                default:    waddr = AW'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0, 1, 2: raddr = AW'($urandom_range(0, NCTRL - 1));
                3, 4:    raddr = AW'($urandom_range('h80, 'h80 + NSTAT - 1));
                5:       raddr = 8'hFF;
                default: raddr = AW'($urandom);
            endcase
            step();
        end

        rst = 1'b0; wen = 1'b0; ren = 1'b0;
        for (int n = 0; n < RDLAT + 1; n++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lb_regbank_resp.md
LB_REGBANK_RESP -- requirements
Module: lb_regbank_resp

Interface
REQ-001 The module SHALL have these parameters: DW, default 32, data width; AW, default 8, local-bus address width; NCTRL, default 16, number of control registers; NSTAT, default 16, number of status inputs; RDLAT, default 2 (range 1..4), read latency in cycles; PULSE_MASK, default 0 (NCTRL bits), per-register self-clearing select; CTRL_INIT, default 0 (NCTRL*DW bits), control register reset values.
REQ-002 lb_clk  in  1  sole clock; all logic is on its rising edge.
REQ-003 lb_reset  in  1  reset, synchronous, active-high.
REQ-004 lb_wen  in  1  write strobe, one write per asserted cycle.
REQ-005 lb_waddr  in  AW  write address.
REQ-006 lb_wdata  in  DW  write data.
REQ-007 lb_ren  in  1  read request strobe, one read per asserted cycle.
REQ-008 lb_raddr  in  AW  read address.
REQ-009 lb_rvalid  out  1  read response valid.
REQ-010 lb_rdata  out  DW  read response data.
REQ-011 lb_rerr  out  1  read address error, qualified by lb_rvalid.
REQ-012 ctrl_q  out  NCTRL*DW  flattened control register values; register i is at bits [i*DW +: DW].
REQ-013 ctrl_wstb  out  NCTRL  one-cycle pulse on bit i when ctrl_q register i is updated.
REQ-014 stat_d  in  NSTAT*DW  flattened status inputs, synchronous to lb_clk.

Function
REQ-015 Address map SHALL be: control i at address i (0..NCTRL-1); status j at address 0x80+j (0..NSTAT-1); COMMIT at address 0xFF; every other address is out of range.
REQ-016 Write to control i with lb_wen=1 in cycle t SHALL make ctrl_q register i equal lb_wdata in cycle t+1, with ctrl_wstb[i]=1 in cycle t+1 only.
REQ-017 Writes to status addresses or out-of-range addresses SHALL be ignored, with no ctrl_q or ctrl_wstb change.
REQ-018 If PULSE_MASK[i]=1, ctrl_q register i SHALL hold the written value for exactly one cycle (t+1) and then return to 0 in cycle t+2, unless written again in cycle t+1.
REQ-019 Read pipeline: lb_ren=1 in cycle t SHALL produce lb_rvalid=1 in cycle t+RDLAT exactly, with lb_rdata and lb_rerr for that request.
REQ-020 Back-to-back reads SHALL be accepted every cycle with no stall; responses SHALL be returned in request order; the pipeline depth is RDLAT.
REQ-021 Read data sources: control read returns the ctrl register value; status read returns stat_d sampled in cycle t; COMMIT read returns 0 with lb_rerr=0.
REQ-022 An out-of-range read SHALL return lb_rdata=0xDEADBEEF (truncated or zero-extended to DW) with lb_rerr=1.
REQ-023 A read and a write to the same control address in the same cycle t SHALL return the pre-write value.
REQ-024 When lb_rvalid=0, lb_rdata SHALL be 0 and lb_rerr SHALL be 0.

Reset
REQ-025 On lb_reset=1, the following SHALL apply at the next edge: ctrl_q register i = CTRL_INIT[i*DW +: DW]; ctrl_wstb=0; lb_rvalid=0; lb_rdata=0; lb_rerr=0; all read-pipeline stages invalidated; shadow registers = CTRL_INIT.
REQ-026 Reads in flight at reset SHALL be dropped and never produce lb_rvalid; writes and reads presented while lb_reset=1 SHALL be ignored.
REQ-027 No ctrl_wstb pulse SHALL be generated by reset itself.

Configuration
REQ-028 Macro LB_REGBANK_SHADOW_EN SHALL select shadowed control writes.
REQ-029 With LB_REGBANK_SHADOW_EN defined, the following SHALL apply: control writes update only shadow register i; control reads return the shadow value; a write of any data to COMMIT in cycle t copies all shadows to ctrl_q in cycle t+1 and pulses ctrl_wstb for every register whose shadow was written since the last commit.
REQ-030 Under LB_REGBANK_SHADOW_EN, if a control write and a COMMIT write coincide, the control write SHALL land in the shadow only and SHALL be committed by the next COMMIT.
REQ-031 Under LB_REGBANK_SHADOW_EN, PULSE_MASK registers SHALL clear one cycle after commit.
REQ-032 Without LB_REGBANK_SHADOW_EN, writes SHALL be direct per REQ-016, COMMIT SHALL be an out-of-range address (read returns 0xDEADBEEF with lb_rerr=1), and no shadow storage SHALL exist.

Verification
REQ-033 Reset, then read address 3 (CTRL_INIT=0) -> lb_rvalid at +RDLAT with lb_rdata=0 and lb_rerr=0.
REQ-034 Write 0x12345678 to address 2 -> next cycle ctrl_q[2]=0x12345678 and ctrl_wstb=0x0004; same-cycle read of address 2 returns the old value.
REQ-035 Reads of 0x80, 0x81, 0x40 on consecutive cycles with stat_d[0]=0xA5, stat_d[1]=0x5A -> three consecutive responses 0xA5, 0x5A, and 0xDEADBEEF with lb_rerr=1.
REQ-036 PULSE_MASK[5]=1, write 0x1 to address 5 -> ctrl_q[5]=1 for one cycle, then 0.
REQ-037 Issue two reads, assert lb_reset the next cycle -> no lb_rvalid is ever seen for those reads.
REQ-038 With LB_REGBANK_SHADOW_EN: write 7 to address 1, ctrl_q[1] unchanged, read returns 7; write COMMIT -> next cycle ctrl_q[1]=7 and ctrl_wstb=0x0002.
